// File: rtl/fmc_arbiter.sv
// fmc_arbiter: round-robin owner of the shared FMC chip<->DDR data path.
// One burst at a time; read and write beats pass through combinationally.
module fmc_arbiter #(
  parameter int NUM_PORT   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORT-1:0]              REQARB_CmdVld,
  output logic [NUM_PORT-1:0]              ARBREQ_CmdRdy,
  input  logic [NUM_PORT-1:0]              REQARB_CmdWr,
  input  logic [NUM_PORT*ADDR_WIDTH-1:0]   REQARB_CmdAddr,
  input  logic [NUM_PORT*LEN_WIDTH-1:0]    REQARB_CmdLen,
  output logic [DATA_WIDTH-1:0]            ARBREQ_RdDat,
  output logic [NUM_PORT-1:0]              ARBREQ_RdDatVld,
  input  logic [NUM_PORT-1:0]              REQARB_RdDatRdy,
  input  logic [NUM_PORT*DATA_WIDTH-1:0]   REQARB_WrDat,
  input  logic [NUM_PORT-1:0]              REQARB_WrDatVld,
  output logic [NUM_PORT-1:0]              ARBREQ_WrDatRdy,
  output logic [ADDR_WIDTH-1:0]            ARBFMC_Addr,
  input  logic [DATA_WIDTH-1:0]            FMCARB_RdDat,
  input  logic                             FMCARB_RdDatVld,
  output logic                             ARBFMC_RdDatRdy,
  output logic [DATA_WIDTH-1:0]            ARBFMC_WrDat,
  output logic                             ARBFMC_WrDatVld,
  input  logic                             FMCARB_WrDatRdy,
  output logic                             ARB_Busy,
  output logic [$clog2(NUM_PORT)-1:0]      ARB_GntId
);

  localparam int IDW = $clog2(NUM_PORT);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t                state;
  state_t                stateNxt;
  logic [IDW-1:0]        ptr;
  logic [IDW-1:0]        gntId;
  logic [ADDR_WIDTH-1:0] addrQ;
  logic [LEN_WIDTH-1:0]  cntQ;

  logic                  found;
  logic [IDW-1:0]        pick;
  logic [IDW-1:0]        idxP;
  int                    idx;
  logic                  accept;
  logic                  beat;

  logic [ADDR_WIDTH-1:0] cmdAddr [NUM_PORT];
  logic [LEN_WIDTH-1:0]  cmdLen  [NUM_PORT];
  logic [DATA_WIDTH-1:0] wrDat   [NUM_PORT];

  for (genvar g = 0; g < NUM_PORT; g++) begin : gSlice
    assign cmdAddr[g] = REQARB_CmdAddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign cmdLen[g]  = REQARB_CmdLen[g*LEN_WIDTH +: LEN_WIDTH];
    assign wrDat[g]   = REQARB_WrDat[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // search starts at ptr so the port served last has lowest priority
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    idxP  = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_PORT) idx = idx - NUM_PORT;
      idxP = IDW'(idx);
      if (!found && REQARB_CmdVld[idxP]) begin
        found = 1'b1;
        pick  = idxP;
      end
    end
  end

  assign accept = found && (state == IDLE) && rst_n;

  always_comb begin
    stateNxt        = state;
    beat            = 1'b0;
    ARBREQ_CmdRdy   = '0;
    ARBREQ_RdDat    = '0;
    ARBREQ_RdDatVld = '0;
    ARBREQ_WrDatRdy = '0;
    ARBFMC_RdDatRdy = 1'b0;
    ARBFMC_WrDat    = '0;
    ARBFMC_WrDatVld = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          ARBREQ_CmdRdy[pick] = 1'b1;
          if (cmdLen[pick] != '0)
            stateNxt = REQARB_CmdWr[pick] ? WR : RD;
        end
      end
      RD: begin
        ARBREQ_RdDat           = FMCARB_RdDat;
        ARBREQ_RdDatVld[gntId] = FMCARB_RdDatVld;
        ARBFMC_RdDatRdy        = REQARB_RdDatRdy[gntId];
        beat = FMCARB_RdDatVld && REQARB_RdDatRdy[gntId];
      end
      WR: begin
        ARBFMC_WrDat           = wrDat[gntId];
        ARBFMC_WrDatVld        = REQARB_WrDatVld[gntId];
        ARBREQ_WrDatRdy[gntId] = FMCARB_WrDatRdy;
        beat = REQARB_WrDatVld[gntId] && FMCARB_WrDatRdy;
      end
      default: stateNxt = IDLE;
    endcase
    if (beat && cntQ == LEN_WIDTH'(1))
      stateNxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      gntId <= '0;
      addrQ <= '0;
      cntQ  <= '0;
    end else begin
      state <= stateNxt;
      if (accept) begin
        gntId <= pick;
        ptr   <= (pick == IDW'(NUM_PORT-1)) ? '0 : pick + 1'b1;
        addrQ <= cmdAddr[pick];
        cntQ  <= cmdLen[pick];
      end else if (beat) begin
        addrQ <= addrQ + 1'b1;
        cntQ  <= cntQ - 1'b1;
      end
    end
  end

  assign ARBFMC_Addr = addrQ;
  assign ARB_Busy    = (state != IDLE);
  assign ARB_GntId   = gntId;

endmodule

// File: tb/tb_fmc_arbiter.sv
// tb_fmc_arbiter: table of bursts plus round-robin and reset sequences.
// Expected grants and beats are queued on drive and popped on DUT output.
module tb_fmc_arbiter;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    cmdVld;
  logic [NP-1:0]    cmdRdy;
  logic [NP-1:0]    cmdWr;
  logic [NP*AW-1:0] cmdAddr;
  logic [NP*LW-1:0] cmdLen;
  logic [DW-1:0]    rdDat;
  logic [NP-1:0]    rdVld;
  logic [NP-1:0]    rdRdy;
  logic [NP*DW-1:0] wrDat;
  logic [NP-1:0]    wrVld;
  logic [NP-1:0]    wrRdy;
  logic [AW-1:0]    fmcAddr;
  logic [DW-1:0]    fmcRdDat;
  logic             fmcRdVld;
  logic             fmcRdRdy;
  logic [DW-1:0]    fmcWrDat;
  logic             fmcWrVld;
  logic             fmcWrRdy;
  logic             busy;
  logic [1:0]       gntId;

  fmc_arbiter #(
    .NUM_PORT(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .REQARB_CmdVld(cmdVld),
    .ARBREQ_CmdRdy(cmdRdy),
    .REQARB_CmdWr(cmdWr),
    .REQARB_CmdAddr(cmdAddr),
    .REQARB_CmdLen(cmdLen),
    .ARBREQ_RdDat(rdDat),
    .ARBREQ_RdDatVld(rdVld),
    .REQARB_RdDatRdy(rdRdy),
    .REQARB_WrDat(wrDat),
    .REQARB_WrDatVld(wrVld),
    .ARBREQ_WrDatRdy(wrRdy),
    .ARBFMC_Addr(fmcAddr),
    .FMCARB_RdDat(fmcRdDat),
    .FMCARB_RdDatVld(fmcRdVld),
    .ARBFMC_RdDatRdy(fmcRdRdy),
    .ARBFMC_WrDat(fmcWrDat),
    .ARBFMC_WrDatVld(fmcWrVld),
    .FMCARB_WrDatRdy(fmcWrRdy),
    .ARB_Busy(busy),
    .ARB_GntId(gntId)
  );

  typedef struct {
    logic [NP-1:0] oh;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } beat_t;

  typedef struct {
    int            port;
    logic          wr;
    logic [AW-1:0] addr;
    int            len;
    int            stallAt;
    int            stallCyc;
    logic [AW-1:0] endAddr;
  } vec_t;

  beat_t         rdQ[$];
  beat_t         wrQ[$];
  int            grantQ[$];
  int            ord[$];
  logic [AW-1:0] pAddr [NP];
  vec_t          vec [5];
  int            total = 0;
  int            bad = 0;
  int            beats = 0;
  int            grantSeen = -1;

  function automatic logic [NP-1:0] onehot(int p);
    logic [NP-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic void chk(string nm, logic [DW-1:0] act,
                              logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  task automatic setCmd(int p, logic w, logic [AW-1:0] a, int n);
    cmdWr[p] = w;
    cmdAddr[p*AW +: AW] = a;
    cmdLen[p*LW +: LW] = LW'(n);
    pAddr[p] = a;
  endtask

  // sample at negedge, then advance to just after the next posedge
  task automatic tick();
    beat_t e;
    int    ex;
    @(negedge clk);
    grantSeen = -1;
    if (|cmdRdy) begin
      ex = grantQ.size() > 0 ? grantQ.pop_front() : -1;
      if (ex < 0) begin
        total++; bad++;
        $display("FAIL grant: got %b want none", cmdRdy);
      end else begin
        chk("grant onehot", DW'(cmdRdy), DW'(onehot(ex)));
      end
      for (int i = 0; i < NP; i++)
        if (cmdRdy[i]) grantSeen = i;
    end
    if (fmcRdVld && fmcRdRdy) begin
      beats++;
      if (rdQ.size() == 0) begin
        total++; bad++;
        $display("FAIL rd beat: got beat at %0h want none", fmcAddr);
      end else begin
        e = rdQ.pop_front();
        chk("rd vld", DW'(rdVld), DW'(e.oh));
        chk("rd addr", DW'(fmcAddr), DW'(e.addr));
        chk("rd dat", rdDat, e.dat);
      end
    end
    if (fmcWrVld && fmcWrRdy) begin
      beats++;
      if (wrQ.size() == 0) begin
        total++; bad++;
        $display("FAIL wr beat: got beat at %0h want none", fmcAddr);
      end else begin
        e = wrQ.pop_front();
        chk("wr rdy", DW'(wrRdy), DW'(e.oh));
        chk("wr addr", DW'(fmcAddr), DW'(e.addr));
        chk("wr dat", fmcWrDat, e.dat);
      end
    end
    @(posedge clk);
    #1;
    if (grantSeen >= 0) cmdVld[grantSeen] = 1'b0;
  endtask

  task automatic chkZero(string tag);
    chk({tag, " cmdRdy"}, DW'(cmdRdy), '0);
    chk({tag, " busy"}, DW'(busy), '0);
    chk({tag, " addr"}, DW'(fmcAddr), '0);
    chk({tag, " rdVld"}, DW'(rdVld), '0);
    chk({tag, " rdDat"}, rdDat, '0);
    chk({tag, " fmcRdRdy"}, DW'(fmcRdRdy), '0);
    chk({tag, " fmcWrVld"}, DW'(fmcWrVld), '0);
    chk({tag, " fmcWrDat"}, fmcWrDat, '0);
    chk({tag, " wrRdy"}, DW'(wrRdy), '0);
    chk({tag, " gntId"}, DW'(gntId), '0);
  endtask

  task automatic runBurst(vec_t v);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            b0;
    setCmd(v.port, v.wr, v.addr, v.len);
    cmdVld[v.port] = 1'b1;
    grantQ.push_back(v.port);
    b0 = beats;
    tick();
    chk("burst gntId", DW'(gntId), DW'(v.port));
    chk("busy after accept", DW'(busy), DW'(v.len != 0));
    a = v.addr;
    d = '0;
    for (int b = 0; b < v.len; b++) begin
      if (b == v.stallAt) begin
        for (int s = 0; s < v.stallCyc; s++) begin
          fmcRdVld = 1'b0;
          fmcWrRdy = 1'b0;
          if (v.wr) wrVld[v.port] = 1'b1;
          tick();
          chk("stall addr", DW'(fmcAddr), DW'(a));
          chk("stall busy", DW'(busy), DW'(1));
        end
      end
      d = {$urandom, $urandom, $urandom, $urandom};
      if (v.wr) begin
        wrDat[v.port*DW +: DW] = d;
        wrVld[v.port] = 1'b1;
        fmcWrRdy = 1'b1;
        wrQ.push_back('{oh: onehot(v.port), addr: a, dat: d});
      end else begin
        fmcRdDat = d;
        fmcRdVld = 1'b1;
        rdQ.push_back('{oh: onehot(v.port), addr: a, dat: d});
      end
      tick();
      a = a + 1'b1;
    end
    fmcRdVld = 1'b0;
    fmcWrRdy = 1'b0;
    wrVld = '0;
    chk("busy after burst", DW'(busy), '0);
    chk("end addr", DW'(fmcAddr), DW'(v.endAddr));
    chk("beat count", DW'(beats - b0), DW'(v.len));
    tick();
  endtask

  // serve len-1 reads for the grant order held in ord
  task automatic serve();
    logic [DW-1:0] d;
    int            p;
    int            w;
    for (int i = 0; i < ord.size(); i++) grantQ.push_back(ord[i]);
    for (int i = 0; i < ord.size(); i++) begin
      p = ord[i];
      w = 0;
      grantSeen = -1;
      while (grantSeen < 0 && w < 8) begin
        tick();
        w++;
      end
      if (grantSeen < 0) begin
        total++; bad++;
        $display("FAIL grant timeout: got none want port %0d", p);
        grantQ.delete();
        return;
      end
      chk("rr gntId", DW'(gntId), DW'(p));
      d = {$urandom, $urandom, $urandom, $urandom};
      fmcRdDat = d;
      fmcRdVld = 1'b1;
      rdQ.push_back('{oh: onehot(p), addr: pAddr[p], dat: d});
      tick();
      fmcRdVld = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    vec[0] = '{port: 2, wr: 1'b0, addr: 32'h100, len: 4,
               stallAt: -1, stallCyc: 0, endAddr: 32'h104};
    vec[1] = '{port: 0, wr: 1'b1, addr: 32'h200, len: 3,
               stallAt: 1, stallCyc: 2, endAddr: 32'h203};
    vec[2] = '{port: 1, wr: 1'b0, addr: 32'h300, len: 0,
               stallAt: -1, stallCyc: 0, endAddr: 32'h300};
    vec[3] = '{port: 1, wr: 1'b1, addr: 32'hFFFF_FFFF, len: 2,
               stallAt: -1, stallCyc: 0, endAddr: 32'h1};
    vec[4] = '{port: 3, wr: 1'b0, addr: 32'h7FFF_FFFE, len: 3,
               stallAt: 2, stallCyc: 1, endAddr: 32'h8000_0001};

    cmdVld = '0; cmdWr = '0; cmdAddr = '0; cmdLen = '0;
    rdRdy = '1; wrDat = '0; wrVld = '0;
    fmcRdDat = '0; fmcRdVld = 1'b0; fmcWrRdy = 1'b0;
    for (int i = 0; i < NP; i++) pAddr[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chkZero("idle");

    for (int i = 0; i < 5; i++) runBurst(vec[i]);

    for (int p = 0; p < NP; p++) setCmd(p, 1'b0, 32'h1000 + 32'(p*16), 1);
    cmdVld = '1;
    ord = {0, 1, 2, 3};
    serve();
    cmdVld = '1;
    ord = {0, 1, 2, 3};
    serve();
    cmdVld = 4'b1010;
    ord = {1, 3};
    serve();
    tick();
    chk("rr idle busy", DW'(busy), '0);

    setCmd(2, 1'b0, 32'h500, 5);
    cmdVld[2] = 1'b1;
    grantQ.push_back(2);
    tick();
    chk("rst burst gntId", DW'(gntId), DW'(2));
    for (int b = 0; b < 2; b++) begin
      fmcRdDat = {$urandom, $urandom, $urandom, $urandom};
      fmcRdVld = 1'b1;
      rdQ.push_back('{oh: onehot(2), addr: 32'h500 + 32'(b), dat: fmcRdDat});
      tick();
    end
    setCmd(3, 1'b0, 32'h600, 1);
    cmdVld[3] = 1'b1;
    fmcRdDat = {$urandom, $urandom, $urandom, $urandom};
    fmcRdVld = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chkZero("in reset");
    fmcRdVld = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    setCmd(0, 1'b0, 32'h700, 1);
    cmdVld[0] = 1'b1;
    ord = {0, 3};
    serve();
    tick();

    chk("rdQ drained", DW'(rdQ.size()), '0);
    chk("wrQ drained", DW'(wrQ.size()), '0);
    chk("grantQ drained", DW'(grantQ.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
